// File: rtl/regfile_pkg.sv
// Shared constants and types for the decode-stage register file.
// Holds default sizes, the zero-register index and the write-port bundle.
package regfile_pkg;

  localparam int XLEN_D   = 32;
  localparam int NREG_D   = 32;
  localparam int ZERO_REG = 0;

  typedef struct packed {
    logic                      we;
    logic [$clog2(NREG_D)-1:0] addr;
    logic [XLEN_D-1:0]         data;
  } wport_t;

endpackage

// File: rtl/regfile_sb_if.sv
// Decode-side bundle for the register file: read ports, two write
// ports, and the pending-load scoreboard controls.
interface regfile_sb_if #(
  parameter int XLEN = 32,
  parameter int NREG = 32
);
  localparam int ABITS = $clog2(NREG);
  localparam int CBITS = $clog2(NREG + 1);

  logic [ABITS-1:0] A1;
  logic [ABITS-1:0] A2;
  logic [XLEN-1:0]  RD1;
  logic [XLEN-1:0]  RD2;
  logic             RDY1;
  logic             RDY2;
  logic             WE3;
  logic [ABITS-1:0] A3;
  logic [XLEN-1:0]  WD3;
  logic             WE4;
  logic [ABITS-1:0] A4;
  logic [XLEN-1:0]  WD4;
  logic             SET_EN;
  logic [ABITS-1:0] SET_A;
  logic             FLUSH;
  logic [CBITS-1:0] PEND_CNT;

  modport master (
    output A1, A2, WE3, A3, WD3, WE4, A4, WD4,
    output SET_EN, SET_A, FLUSH,
    input  RD1, RD2, RDY1, RDY2, PEND_CNT
  );

  modport slave (
    input  A1, A2, WE3, A3, WD3, WE4, A4, WD4,
    input  SET_EN, SET_A, FLUSH,
    output RD1, RD2, RDY1, RDY2, PEND_CNT
  );

endinterface

// File: rtl/regfile_sb_counter.sv
// Pending-load scoreboard: one bit per register plus a running
// population count kept in step with the bit vector.
module sb_counter
  import regfile_pkg::*;
#(
  parameter int NREG  = NREG_D,
  parameter int ABITS = $clog2(NREG),
  parameter int CBITS = $clog2(NREG + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set_en,
  input  logic [ABITS-1:0] set_a,
  input  logic             clr_en,
  input  logic [ABITS-1:0] clr_a,
  input  logic             flush,
  output logic [NREG-1:0]  pend,
  output logic [CBITS-1:0] cnt
);

  logic            set_ok;
  logic            clr_ok;
  logic            inc;
  logic            dec;
  logic [NREG-1:0] set_m;
  logic [NREG-1:0] clr_m;

  // A new load to the same register outranks its returning load
  assign set_ok = set_en && (set_a != ABITS'(ZERO_REG));
  assign clr_ok = clr_en && !(set_ok && (set_a == clr_a));
  assign inc    = set_ok && !pend[set_a];
  assign dec    = clr_ok && pend[clr_a];

  always_comb begin
    set_m = '0;
    clr_m = '0;
    if (set_ok) set_m[set_a] = 1'b1;
    if (clr_ok) clr_m[clr_a] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= '0;
      cnt  <= '0;
    end else if (flush) begin
      pend <= '0;
      cnt  <= '0;
    end else begin
      pend <= (pend | set_m) & ~clr_m;
      cnt  <= cnt + CBITS'(inc) - CBITS'(dec);
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Two-write-port register file with write bypass and a
// pending-load scoreboard feeding per-operand ready flags.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int XLEN = XLEN_D,
  parameter int NREG = NREG_D
) (
  input  logic       CLK,
  input  logic       RST,
  regfile_sb_if.slave bus
);

  localparam int ABITS = $clog2(NREG);
  localparam int CBITS = $clog2(NREG + 1);
  localparam logic [ABITS-1:0] ZA = ABITS'(ZERO_REG);

  logic [XLEN-1:0]  mem [NREG];
  logic [NREG-1:0]  pend;
  logic [CBITS-1:0] cnt;
  logic [ABITS-1:0] ra   [2];
  logic [XLEN-1:0]  rdat [2];
  logic             rrdy [2];

  sb_counter #(
    .NREG  (NREG),
    .ABITS (ABITS),
    .CBITS (CBITS)
  ) u_sb (
    .clk    (CLK),
    .rst    (RST),
    .set_en (bus.SET_EN),
    .set_a  (bus.SET_A),
    .clr_en (bus.WE4),
    .clr_a  (bus.A4),
    .flush  (bus.FLUSH),
    .pend   (pend),
    .cnt    (cnt)
  );

  // WD3 is written last so the younger ALU result wins a collision
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else begin
      if (bus.WE4 && bus.A4 != ZA) mem[bus.A4] <= bus.WD4;
      if (bus.WE3 && bus.A3 != ZA) mem[bus.A3] <= bus.WD3;
    end
  end

  assign ra[0] = bus.A1;
  assign ra[1] = bus.A2;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      rdat[i] = mem[ra[i]];
      if (ra[i] == ZA)
        rdat[i] = '0;
      else if (bus.WE3 && bus.A3 == ra[i])
        rdat[i] = bus.WD3;
      else if (bus.WE4 && bus.A4 == ra[i])
        rdat[i] = bus.WD4;
      rrdy[i] = (ra[i] == ZA) || !pend[ra[i]] ||
                (bus.WE4 && bus.A4 == ra[i]);
    end
  end

  assign bus.RD1      = rdat[0];
  assign bus.RD2      = rdat[1];
  assign bus.RDY1     = rrdy[0];
  assign bus.RDY2     = rrdy[1];
  assign bus.PEND_CNT = cnt;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed vector bench for regfile_sb: table of per-cycle vectors
// plus hand sequences for asynchronous reset.
module tb_regfile_sb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  regfile_sb_if #(.XLEN(32), .NREG(32)) bus ();

  regfile_sb #(.XLEN(32), .NREG(32)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic        we3;
    logic [4:0]  a3;
    logic [31:0] wd3;
    logic        we4;
    logic [4:0]  a4;
    logic [31:0] wd4;
    logic        se;
    logic [4:0]  sa;
    logic        fl;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        y1;
    logic        y2;
    logic [5:0]  cnt;
  } vec_t;

  vec_t vq[$];

  task automatic drive(vec_t v);
    bus.A1 = v.a1;
    bus.A2 = v.a2;
    bus.WE3 = v.we3;
    bus.A3 = v.a3;
    bus.WD3 = v.wd3;
    bus.WE4 = v.we4;
    bus.A4 = v.a4;
    bus.WD4 = v.wd4;
    bus.SET_EN = v.se;
    bus.SET_A = v.sa;
    bus.FLUSH = v.fl;
  endtask

  task automatic cmp(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic check_vec(int idx, vec_t v);
    n_vec++;
    if (bus.RD1 !== v.rd1 || bus.RD2 !== v.rd2 ||
        bus.RDY1 !== v.y1 || bus.RDY2 !== v.y2 ||
        bus.PEND_CNT !== v.cnt) begin
      n_err++;
      $display("FAIL vec%0d: got rd1=%h rd2=%h rdy=%b%b cnt=%0d want rd1=%h rd2=%h rdy=%b%b cnt=%0d",
        idx, bus.RD1, bus.RD2, bus.RDY1, bus.RDY2, bus.PEND_CNT,
        v.rd1, v.rd2, v.y1, v.y2, v.cnt);
    end
  endtask

  initial begin
    vec_t idle;
    idle = '0;
    drive(idle);

    //           a1 a2 we3 a3 wd3     we4 a4 wd4    se sa fl  rd1     rd2     y1 y2 cnt
    vq.push_back('{5, 0, 0, 0, 0,      0, 0, 0,     0, 0, 0,  0,      0,      1, 1, 0});
    vq.push_back('{7, 0, 1, 7, 'h1234, 0, 0, 0,     0, 0, 0,  'h1234, 0,      1, 1, 0});
    vq.push_back('{7, 0, 0, 0, 0,      0, 0, 0,     0, 0, 0,  'h1234, 0,      1, 1, 0});
    vq.push_back('{9, 9, 1, 9, 'hA,    1, 9, 'hB,   0, 0, 0,  'hA,    'hA,    1, 1, 0});
    vq.push_back('{9, 7, 0, 0, 0,      0, 0, 0,     0, 0, 0,  'hA,    'h1234, 1, 1, 0});
    vq.push_back('{4, 0, 0, 0, 0,      0, 0, 0,     1, 4, 0,  0,      0,      1, 1, 0});
    vq.push_back('{4, 0, 0, 0, 0,      0, 0, 0,     0, 0, 0,  0,      0,      0, 1, 1});
    vq.push_back('{4, 0, 0, 0, 0,      0, 0, 0,     0, 0, 0,  0,      0,      0, 1, 1});
    vq.push_back('{4, 0, 0, 0, 0,      1, 4, 'h55,  0, 0, 0,  'h55,   0,      1, 1, 1});
    vq.push_back('{4, 0, 0, 0, 0,      0, 0, 0,     0, 0, 0,  'h55,   0,      1, 1, 0});
    vq.push_back('{3, 0, 0, 0, 0,      0, 0, 0,     1, 3, 0,  0,      0,      1, 1, 0});
    vq.push_back('{3, 0, 0, 0, 0,      1, 3, 'h77,  1, 3, 0,  'h77,   0,      1, 1, 1});
    vq.push_back('{3, 0, 0, 0, 0,      0, 0, 0,     0, 0, 0,  'h77,   0,      0, 1, 1});
    vq.push_back('{0, 0, 0, 0, 0,      0, 0, 0,     1, 0, 0,  0,      0,      1, 1, 1});
    vq.push_back('{3, 0, 1, 3, 'h99,   0, 0, 0,     0, 0, 0,  'h99,   0,      0, 1, 1});
    vq.push_back('{3, 0, 0, 0, 0,      1, 3, 'h88,  0, 0, 0,  'h88,   0,      1, 1, 1});
    vq.push_back('{0, 0, 0, 0, 0,      0, 0, 0,     1, 1, 0,  0,      0,      1, 1, 0});
    vq.push_back('{0, 0, 0, 0, 0,      0, 0, 0,     1, 2, 0,  0,      0,      1, 1, 1});
    vq.push_back('{1, 2, 0, 0, 0,      0, 0, 0,     1, 6, 0,  0,      0,      0, 0, 2});
    vq.push_back('{1, 6, 0, 0, 0,      0, 0, 0,     1, 8, 1,  0,      0,      0, 0, 3});
    vq.push_back('{8, 6, 0, 0, 0,      0, 0, 0,     0, 0, 0,  0,      0,      1, 1, 0});
    vq.push_back('{0, 0, 1, 0, 'hFF,   1, 0, 'hEE,  0, 0, 0,  0,      0,      1, 1, 0});
    vq.push_back('{9, 3, 0, 0, 0,      0, 0, 0,     0, 0, 0,  'hA,    'h88,   1, 1, 0});
    vq.push_back('{10,11,1, 10,'h111,  1, 11,'h222, 0, 0, 0,  'h111,  'h222,  1, 1, 0});
    vq.push_back('{10,11,0, 0, 0,      0, 0, 0,     0, 0, 0,  'h111,  'h222,  1, 1, 0});

    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i]);
      #1;
      check_vec(i, vq[i]);
      @(posedge clk);
      @(negedge clk);
    end

    // Pend r5, then assert reset between edges
    drive(idle);
    bus.SET_EN = 1'b1;
    bus.SET_A = 5'd5;
    bus.A1 = 5'd7;
    bus.A2 = 5'd5;
    #1;
    cmp("pre_rst_rd1", bus.RD1, 32'h1234);
    @(posedge clk);
    @(negedge clk);
    bus.SET_EN = 1'b0;
    #1;
    cmp("pre_rst_cnt", 32'(bus.PEND_CNT), 32'd1);
    cmp("pre_rst_rdy2", 32'(bus.RDY2), 32'd0);
    #1;
    rst = 1'b1;
    #1;
    cmp("rst_rd1", bus.RD1, 32'h0);
    cmp("rst_cnt", 32'(bus.PEND_CNT), 32'd0);
    cmp("rst_rdy2", 32'(bus.RDY2), 32'd1);

    // A write presented while reset is held must be lost
    bus.WE3 = 1'b1;
    bus.A3 = 5'd12;
    bus.WD3 = 32'h5;
    @(posedge clk);
    @(negedge clk);
    bus.WE3 = 1'b0;
    rst = 1'b0;
    bus.A1 = 5'd12;
    bus.A2 = 5'd9;
    #1;
    cmp("rst_wr_lost", bus.RD1, 32'h0);
    cmp("rst_r9", bus.RD2, 32'h0);
    @(posedge clk);
    @(negedge clk);
    cmp("post_rst_cnt", 32'(bus.PEND_CNT), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
